vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Source end of the scan interface: produces the hCount/vCount raster
//   position, the bright window and the hSync/vSync pulses that the pixel
//   generator consumes. It derives a 25 MHz pixel tick from the 100 MHz
//   system clock. The sync and bright outputs can be delayed by whole pixel
//   ticks so that they stay aligned with the pixel generator's registered
//   sprite/ROM rgb path.
// PARAMETERS
//   CLK_DIV      4    system clocks per pixel; must be >= 2
//   H_TOTAL      800  pixel ticks per line
//   H_SYNC       96   hSync low while hCount < H_SYNC
//   H_VIS_START  144  first visible column, inclusive
//   H_VIS_END    784  first non-visible column after the visible area, exclusive
//   V_TOTAL      525  lines per frame
//   V_SYNC       2    vSync low while vCount < V_SYNC
//   V_VIS_START  35   first visible line, inclusive
//   V_VIS_END    515  first non-visible line after the visible area, exclusive
//   SYNC_DELAY   1    extra pixel-tick stages applied to hSync, vSync and bright (0..3)
// PORTS
//   clk          in   1   100 MHz system clock
//   rst_l        in   1   asynchronous active-low reset
//   hCount       out  10  current column, 0..H_TOTAL-1
//   vCount       out  10  current line, 0..V_TOTAL-1
//   bright       out  1   1 inside the visible window; delayed by SYNC_DELAY
//   hSync        out  1   horizontal sync, active low; delayed by SYNC_DELAY
//   vSync        out  1   vertical sync, active low; delayed by SYNC_DELAY
//   pix_tick     out  1   1-clk pulse: hCount/vCount just advanced
//   line_start   out  1   1-clk pulse with pix_tick when hCount becomes 0
//   frame_start  out  1   1-clk pulse with pix_tick when hCount=0 and vCount=0
// BEHAVIOUR
//   Reset (async assert, synchronous release):
//   - div=0, hCount=0, vCount=0, bright=0, hSync=1, vSync=1.
//   - pix_tick, line_start and frame_start are 0; delay stages are cleared
//     to the inactive values (bright=0, syncs=1).
//   Divider:
//   - div counts 0..CLK_DIV-1 and wraps.
//   - On the clk edge where div==CLK_DIV-1, the counters advance.
//   - pix_tick is registered and goes high for the clk cycle that follows
//     that edge, so it is 1 clk out of every CLK_DIV.
//   - The first advance happens CLK_DIV clks after reset release.
//   Counters (update only on the advance edge):
//   - hCount = (hCount==H_TOTAL-1) ? 0 : hCount+1.
//   - vCount increments only when hCount wraps.
//   - vCount = (vCount==V_TOTAL-1) ? 0 : vCount+1.
//   - Simultaneous h and v wrap gives (0,0) and asserts frame_start.
//   - Counters never exceed TOTAL-1. No saturation, no extra wrap states.
//   Decode (stage 0):
//   - Computed from the next counter values and registered on the same
//     advance edge, so stage 0 is aligned with hCount/vCount.
//   - h_s = !(hCount < H_SYNC).
//   - v_s = !(vCount < V_SYNC).
//   - b = (hCount >= H_VIS_START && hCount < H_VIS_END &&
//          vCount >= V_VIS_START && vCount < V_VIS_END).
//   Delay:
//   - A shift register of length SYNC_DELAY, advanced only on advance edges.
//   - The outputs are its last stage, or stage 0 when SYNC_DELAY=0.
//   - Net effect: hSync, vSync and bright lag hCount/vCount by SYNC_DELAY
//     pixel ticks.
//   Pulses: line_start and frame_start are registered and are never high
//     unless pix_tick is also high.
//   Mid-operation reset: everything returns to the reset values
//     immediately. After release the raster restarts at (0,0). No partial
//     line is completed.
//   Widths: arithmetic is 10-bit unsigned. No comparison depends on
//     overflow, since H_TOTAL and V_TOTAL are <= 1024.
// TESTING
//   T1 Reset:
//      - Hold rst_l=0 for 10 clks.
//      - Required: hCount=0, vCount=0, bright=0, hSync=1, vSync=1,
//        pix_tick=0 throughout.
//   T2 Divider:
//      - Release reset.
//      - Required: hCount=1 after 4 clks, hCount=2 after 8 clks.
//      - Required: pix_tick high exactly 1 clk of every 4.
//   T3 Line wrap:
//      - Run to hCount=799, vCount=10, then one more tick.
//      - Required: hCount=0, vCount=11, line_start=1 for 1 clk,
//        frame_start=0.
//   T4 Frame wrap:
//      - Run to (799,524), then one more tick.
//      - Required: (0,0), frame_start=1 for 1 clk.
//      - Required: exactly 420000 pix_ticks between consecutive
//        frame_starts.
//   T5 Sync and bright with SYNC_DELAY=1:
//      - Required: hSync low for 96 ticks (384 clks), starting the tick
//        after hCount=0.
//      - Required: on line 35, bright rises the tick after hCount=144 and
//        falls the tick after hCount=784.
//      - Required: bright=0 on lines 0..34 and 515..524.
//      - Required: vSync low for 2 lines.
//   T6 Mid-frame reset:
//      - Assert rst_l=0 at (400,200) for 3 clks, then release.
//      - Required: outputs take the reset values within the same cycle.
//      - Required: the raster restarts at (0,0), with the first advance
//        4 clks after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: divides clk to a pixel tick and generates the raster position,
// sync pulses and bright window, with syncs/bright delayed by SYNC_DELAY pixel ticks.
module vga_timing_gen #(
   parameter int CLK_DIV     = 4,
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_VIS_START = 144,
   parameter int H_VIS_END   = 784,
   parameter int V_TOTAL     = 525,
   parameter int V_SYNC      = 2,
   parameter int V_VIS_START = 35,
   parameter int V_VIS_END   = 515,
   parameter int SYNC_DELAY  = 1
) (
   input  logic       clk,
   input  logic       rst_l,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       bright,
   output logic       hSync,
   output logic       vSync,
   output logic       pix_tick,
   output logic       line_start,
   output logic       frame_start
);
   localparam int DW = $clog2(CLK_DIV);
   logic [DW-1:0] r_div;
   logic [9:0]    r_h, r_v, w_h_nxt, w_v_nxt;
   logic          w_adv, w_h_wrap, w_hs0, w_vs0, w_b0, r_hs0, r_vs0, r_b0;
   assign w_adv    = r_div == DW'(CLK_DIV - 1);
   assign w_h_wrap = r_h == 10'(H_TOTAL - 1);
   assign w_h_nxt  = w_h_wrap ? 10'd0 : r_h + 10'd1;
   assign w_v_nxt  = !w_h_wrap ? r_v : (r_v == 10'(V_TOTAL - 1)) ? 10'd0 : r_v + 10'd1;
   // stage 0 decodes the next position so it lands together with the counters
   assign w_hs0 = w_h_nxt >= 10'(H_SYNC);
   assign w_vs0 = w_v_nxt >= 10'(V_SYNC);
   assign w_b0  = w_h_nxt >= 10'(H_VIS_START) && w_h_nxt < 10'(H_VIS_END) &&
                  w_v_nxt >= 10'(V_VIS_START) && w_v_nxt < 10'(V_VIS_END);
   assign hCount = r_h;
   assign vCount = r_v;
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) begin
         r_div       <= '0;
         r_h         <= '0;
         r_v         <= '0;
         r_hs0       <= 1'b1;
         r_vs0       <= 1'b1;
         r_b0        <= 1'b0;
         pix_tick    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         r_div       <= w_adv ? '0 : r_div + DW'(1);
         pix_tick    <= w_adv;
         line_start  <= w_adv && w_h_nxt == 10'd0;
         frame_start <= w_adv && w_h_nxt == 10'd0 && w_v_nxt == 10'd0;
         if (w_adv) begin
            r_h   <= w_h_nxt;
            r_v   <= w_v_nxt;
            r_hs0 <= w_hs0;
            r_vs0 <= w_vs0;
            r_b0  <= w_b0;
         end
      end
   if (SYNC_DELAY == 0) begin : g_nodly
      assign {hSync, vSync, bright} = {r_hs0, r_vs0, r_b0};
   end else begin : g_dly
      logic [2:0] r_pipe [SYNC_DELAY];
      always_ff @(posedge clk or negedge rst_l)
         if (!rst_l) begin
            for (int i = 0; i < SYNC_DELAY; i++) r_pipe[i] <= 3'b110;
         end else if (w_adv) begin
            r_pipe[0] <= {r_hs0, r_vs0, r_b0};
            for (int i = 1; i < SYNC_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
         end
      assign {hSync, vSync, bright} = r_pipe[SYNC_DELAY-1];
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: compares a full-size and a shrunken raster against a
// time-based reference model under randomized resets.
module tb_vga_timing_gen;
   localparam int S_DIV = 3, S_HT = 40, S_HS = 5, S_HVS = 8, S_HVE = 36;
   localparam int S_VT = 20, S_VS = 2, S_VVS = 3, S_VVE = 17, S_DLY = 2;
   logic       clk = 0, rst_b = 0, rst_s = 0;
   logic [9:0] h_b, v_b, h_s, v_s;
   logic       br_b, hs_b, vs_b, pt_b, ls_b, fs_b;
   logic       br_s, hs_s, vs_s, pt_s, ls_s, fs_s;
   int         c_b = 0, c_s = 0, n_chk = 0, n_pass = 0;
   int         fcnt = 0, ptcnt = 0;
   bit         fseen = 0, done = 0;
   always #5 clk = ~clk;
   vga_timing_gen u_big (
      .clk(clk), .rst_l(rst_b), .hCount(h_b), .vCount(v_b), .bright(br_b),
      .hSync(hs_b), .vSync(vs_b), .pix_tick(pt_b), .line_start(ls_b), .frame_start(fs_b));
   vga_timing_gen #(
      .CLK_DIV(S_DIV), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_VIS_START(S_HVS), .H_VIS_END(S_HVE),
      .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_VIS_START(S_VVS), .V_VIS_END(S_VVE), .SYNC_DELAY(S_DLY)
   ) u_small (
      .clk(clk), .rst_l(rst_s), .hCount(h_s), .vCount(v_s), .bright(br_s),
      .hSync(hs_s), .vSync(vs_s), .pix_tick(pt_s), .line_start(ls_s), .frame_start(fs_s));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask
   // Expected {h,v,bright,hSync,vSync,pix_tick,line_start,frame_start} after c clocks since release
   function automatic logic [31:0] model(input int c, input bit rn, input int dv, input int ht,
         input int vt, input int hsy, input int vsy, input int hvs, input int hve,
         input int vvs, input int vve, input int dly);
      int n, p, q, qh, qv;
      logic b, hs, vs, pt;
      if (!rn) return {6'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3'b000};
      n  = c / dv;
      p  = n % (ht * vt);
      pt = c > 0 && c % dv == 0;
      if (n <= dly) {b, hs, vs} = 3'b011;
      else begin
         q  = (n - dly) % (ht * vt);
         qh = q % ht;
         qv = q / ht;
         hs = qh >= hsy;
         vs = qv >= vsy;
         b  = qh >= hvs && qh < hve && qv >= vvs && qv < vve;
      end
      return {6'd0, 10'(p % ht), 10'(p / ht), b, hs, vs, pt, pt && p % ht == 0, pt && p == 0};
   endfunction
   always @(posedge clk or negedge rst_b) if (!rst_b) c_b <= 0; else c_b <= c_b + 1;
   always @(posedge clk or negedge rst_s) if (!rst_s) c_s <= 0; else c_s <= c_s + 1;
   always @(negedge clk) if (!done) begin
      chk("big", {6'd0, h_b, v_b, br_b, hs_b, vs_b, pt_b, ls_b, fs_b},
          model(c_b, rst_b, 4, 800, 525, 96, 2, 144, 784, 35, 515, 1));
      chk("small", {6'd0, h_s, v_s, br_s, hs_s, vs_s, pt_s, ls_s, fs_s},
          model(c_s, rst_s, S_DIV, S_HT, S_VT, S_HS, S_VS, S_HVS, S_HVE, S_VVS, S_VVE, S_DLY));
      if (!rst_s) begin
         fcnt  = 0;
         fseen = 0;
      end else if (pt_s) begin
         fcnt++;
         if (fs_s) begin
            if (fseen) chk("frame_period", fcnt, S_HT * S_VT);
            fcnt  = 0;
            fseen = 1;
         end
      end
   end
   task automatic small_reset(input int hold);
      @(posedge clk);
      #1 rst_s = 0;
      #1 chk("async_rst", {h_s, v_s, br_s, hs_s, vs_s, pt_s, ls_s, fs_s}, {20'd0, 6'b011000});
      repeat (hold) @(posedge clk);
      #1 rst_s = 1;
   endtask
   initial begin
      repeat ($urandom_range(10, 14)) @(posedge clk);
      #1 rst_b = 1;
      rst_s = 1;
      fork
         begin
            repeat (4) @(posedge clk);
            @(negedge clk) chk("t2_h1", h_b, 1);
            repeat (4) @(posedge clk);
            @(negedge clk) chk("t2_h2", h_b, 2);
            repeat (400) @(negedge clk) ptcnt += pt_b;
            chk("t2_ratio", ptcnt, 100);
            for (int i = 0; i < 40000 && !(h_b == 799 && v_b == 10); i++) @(negedge clk);
            if (!(h_b == 799 && v_b == 10)) chk("t3_reach", 0, 1);
            else begin
               repeat (4) @(negedge clk);
               chk("t3_pos", {h_b, v_b}, {10'd0, 10'd11});
               chk("t3_pulses", {pt_b, ls_b, fs_b}, 3'b110);
               @(negedge clk) chk("t3_ls_off", ls_b, 0);
            end
         end
         begin
            repeat (3) begin
               repeat ($urandom_range(1500, 3000)) @(posedge clk);
               small_reset($urandom_range(1, 5));
            end
            for (int i = 0; i < 3000 && !(h_s == 20 && v_s == 10); i++) @(negedge clk);
            if (!(h_s == 20 && v_s == 10)) chk("t6_reach", 0, 1);
            small_reset(3);
            repeat (S_DIV - 1) @(posedge clk);
            @(negedge clk) chk("t6_hold", {h_s, v_s}, 20'd0);
            @(posedge clk);
            @(negedge clk) chk("t6_first", {h_s, v_s, pt_s}, {10'd1, 10'd0, 1'b1});
         end
      join
      @(negedge clk) done = 1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
